// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide op encoding and default unit latencies.
// Also holds the scheduler state type so checkers can refer to it by name.
package cpu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply / 32/32 divide producing a {hi, lo} pair.
// The divider works on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
module md_arith
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic        [31:0] a_mag;
  logic        [31:0] b_mag;
  logic        [31:0] b_safe;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic        [31:0] quot;
  logic        [31:0] rem;

  always_comb begin
    prod_s     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u     = {32'd0, a} * {32'd0, b};

    div_signed = (op == MD_DIV);
    a_neg      = div_signed & a[31];
    b_neg      = div_signed & b[31];
    a_mag      = a_neg ? (~a + 32'd1) : a;
    b_mag      = b_neg ? (~b + 32'd1) : b;
    // A zero divisor is replaced by 1 only to keep the divider defined; the result is discarded.
    b_safe     = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_hi   = rem;
        res_lo   = quot;
        div_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler beside the E stage: owns HI/LO, models unit latency
// with a busy countdown, and stalls D / bubbles E while a D-stage HI/LO user waits.
module md_sched
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_d,
  output logic        flush_e
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       shadow_hi_q, shadow_hi_d;
  logic [31:0]       shadow_lo_q, shadow_lo_d;
  logic              shadow_dz_q, shadow_dz_d;

  logic [31:0]       res_hi;
  logic [31:0]       res_lo;
  logic              res_dz;
  logic              start_md;

  md_arith u_arith (
    .op       (md_op),
    .a        (a),
    .b        (b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (res_dz)
  );

  always_comb begin
    start_md = start & ((md_op == MD_MULT) | (md_op == MD_MULTU) |
                        (md_op == MD_DIV)  | (md_op == MD_DIVU));

    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    shadow_dz_d = shadow_dz_q;

    case (state_q)
      MD_IDLE: begin
        if (start_md) begin
          shadow_hi_d = res_hi;
          shadow_lo_d = res_lo;
          shadow_dz_d = res_dz;
          state_d     = MD_BUSY;
          cnt_d       = ((md_op == MD_MULT) | (md_op == MD_MULTU)) ?
                        CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (start && (md_op == MD_MTHI)) begin
          hi_d = a;
        end else if (start && (md_op == MD_MTLO)) begin
          lo_d = a;
        end
      end
      MD_BUSY: begin
        // Any start seen here is dropped; the D-stage stall keeps it from being legal.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          if (!shadow_dz_q) begin
            hi_d = shadow_hi_q;
            lo_d = shadow_lo_q;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      shadow_dz_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      shadow_dz_q <= shadow_dz_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state_q == MD_BUSY);
  assign stall_d = d_is_md & (busy | start_md);
  assign flush_e = stall_d;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched: latency, arithmetic corner cases,
// stall/flush generation, HI/LO moves and reset during a busy operation.
module tb_md_sched;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_d;
  logic        flush_e;

  int n_cmp = 0;
  int n_err = 0;

  md_sched #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .start   (start),
    .md_op   (md_op),
    .a       (a),
    .b       (b),
    .d_is_md (d_is_md),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall_d (stall_d),
    .flush_e (flush_e)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start   = 1'b0;
    md_op   = MD_NONE;
    a       = 32'd0;
    b       = 32'd0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    idle_inputs();
    d_is_md = 1'b1;
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", lo); end
    n_cmp++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall_d); end
    tick();
    tick();
    rst_n   = 1'b1;
    d_is_md = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    a = 32'hFFFFFFFE; b = 32'd3; md_op = MD_MULT; start = 1'b1;
    #1;
    n_cmp++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL mult_stall_nod got=%b exp=0", stall_d); end
    tick();
    idle_inputs();
    for (int i = 1; i <= 5; i++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy c%0d got=%b exp=1", i, busy); end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mult_done got=%b exp=0", busy); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFFA) begin n_err++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_multu();
    a = 32'hFFFFFFFF; b = 32'd2; md_op = MD_MULTU; start = 1'b1;
    tick();
    idle_inputs();
    for (int i = 1; i <= 5; i++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL multu_busy c%0d got=%b exp=1", i, busy); end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multu_done got=%b exp=0", busy); end
    n_cmp++; if (hi !== 32'h00000001) begin n_err++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
  endtask

  task automatic test_div_stall();
    d_is_md = 1'b1;
    a = 32'hFFFFFFF9; b = 32'd2; md_op = MD_DIV; start = 1'b1;
    #1;
    n_cmp++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL div_stall_start got=%b exp=1", stall_d); end
    n_cmp++; if (flush_e !== 1'b1) begin n_err++; $display("FAIL div_flush_start got=%b exp=1", flush_e); end
    tick();
    idle_inputs();
    #1;
    for (int i = 1; i <= 10; i++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL div_busy c%0d got=%b exp=1", i, busy); end
      n_cmp++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL div_stall c%0d got=%b exp=1", i, stall_d); end
      n_cmp++; if (flush_e !== 1'b1) begin n_err++; $display("FAIL div_flush c%0d got=%b exp=1", i, flush_e); end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL div_done got=%b exp=0", busy); end
    n_cmp++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL div_stall_after got=%b exp=0", stall_d); end
    n_cmp++; if (flush_e !== 1'b0) begin n_err++; $display("FAIL div_flush_after got=%b exp=0", flush_e); end
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    d_is_md = 1'b0;
  endtask

  task automatic test_move_and_div_zero();
    a = 32'h11; md_op = MD_MTHI; start = 1'b1;
    tick();
    n_cmp++; if (hi !== 32'h11) begin n_err++; $display("FAIL mthi_hi got=%h exp=00000011", hi); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    a = 32'h22; md_op = MD_MTLO;
    tick();
    n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL mtlo_lo got=%h exp=00000022", lo); end
    n_cmp++; if (hi !== 32'h11) begin n_err++; $display("FAIL mtlo_hi_kept got=%h exp=00000011", hi); end
    // NONE and the unused code 7 must leave everything alone
    a = 32'hDEAD; md_op = MD_NONE;
    tick();
    md_op = 3'd7;
    tick();
    n_cmp++; if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      n_err++; $display("FAIL noop_ops got busy=%b hi=%h lo=%h exp busy=0 hi=11 lo=22", busy, hi, lo);
    end
    a = 32'd100; b = 32'd0; md_op = MD_DIVU; start = 1'b1;
    tick();
    idle_inputs();
    for (int i = 1; i <= 10; i++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dz_busy c%0d got=%b exp=1", i, busy); end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dz_done got=%b exp=0", busy); end
    n_cmp++; if (hi !== 32'h11) begin n_err++; $display("FAIL dz_hi got=%h exp=00000011", hi); end
    n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL dz_lo got=%h exp=00000022", lo); end
  endtask

  task automatic test_div_overflow();
    a = 32'h80000000; b = 32'hFFFFFFFF; md_op = MD_DIV; start = 1'b1;
    tick();
    idle_inputs();
    for (int i = 1; i <= 10; i++) tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_done got=%b exp=0", busy); end
    n_cmp++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL ovf_lo got=%h exp=80000000", lo); end
    n_cmp++; if (hi !== 32'h00000000) begin n_err++; $display("FAIL ovf_hi got=%h exp=00000000", hi); end
  endtask

  task automatic test_reset_mid_busy();
    a = 32'd7; b = 32'd9; md_op = MD_MULT; start = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_hilo got hi=%h lo=%h exp 0/0", hi, lo);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_discard got hi=%h lo=%h busy=%b exp 0/0/0", hi, lo, busy);
    end
    a = 32'd5; md_op = MD_MTLO; start = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (lo !== 32'd5) begin n_err++; $display("FAIL rst_mtlo got=%h exp=00000005", lo); end
  endtask

  task automatic test_back_to_back();
    d_is_md = 1'b0;
    a = 32'd100; b = 32'd7; md_op = MD_DIV; start = 1'b1;
    #1;
    n_cmp++; if (stall_d !== 1'b0 || flush_e !== 1'b0) begin
      n_err++; $display("FAIL b2b_stall_start got=%b/%b exp=0/0", stall_d, flush_e);
    end
    tick();
    idle_inputs();
    for (int i = 1; i <= 10; i++) begin
      // An illegal second start lands in busy cycle 2
      if (i == 2) begin
        a = 32'd3; b = 32'd3; md_op = MD_MULT; start = 1'b1;
      end else begin
        idle_inputs();
      end
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy c%0d got=%b exp=1", i, busy); end
      n_cmp++; if (stall_d !== 1'b0 || flush_e !== 1'b0) begin
        n_err++; $display("FAIL b2b_stall c%0d got=%b/%b exp=0/0", i, stall_d, flush_e);
      end
      tick();
    end
    idle_inputs();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_done got=%b exp=0", busy); end
    n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL b2b_lo got=%h exp=0000000e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL b2b_hi got=%h exp=00000002", hi); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_no_restart got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div_stall();
    test_move_and_div_zero();
    test_div_overflow();
    test_reset_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
